// File: rtl/uart_apb_arb_pkg.sv
// Shared types for the UART APB arbiter: FSM states, requester id and the
// UART register map.
package uart_apb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } state_e;

   localparam int unsigned ID_W = 1;
   typedef logic [ID_W-1:0] id_t;

   typedef enum logic [3:0] {
      REG_TX          = 4'd0,
      REG_RX          = 4'd1,
      REG_BAUD        = 4'd2,
      REG_CONF        = 4'd3,
      REG_RXTRIG      = 4'd4,
      REG_TXTRIG      = 4'd5,
      REG_DELAY       = 4'd6,
      REG_STATUS      = 4'd7,
      REG_RXFIFO_STAT = 4'd8,
      REG_TXFIFO_STAT = 4'd9
   } uart_reg_e;

endpackage

// File: rtl/uart_apb_arb_if.sv
// Requester-side command/response bundle of the UART APB arbiter.
// Optional macro UART_ARB_LOCK_EN adds the req_lock signal.
interface uart_apb_arb_if #(
   parameter int unsigned ADDR_W = 4,
   parameter int unsigned DATA_W = 32
);
   logic              req_valid;
   logic              req_ready;
   logic              req_write;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_wdata;
   logic              rsp_valid;
   logic [DATA_W-1:0] rsp_rdata;
`ifdef UART_ARB_LOCK_EN
   logic              req_lock;

   modport master (output req_valid, req_write, req_addr, req_wdata, req_lock,
                   input  req_ready, rsp_valid, rsp_rdata);
   modport slave  (input  req_valid, req_write, req_addr, req_wdata, req_lock,
                   output req_ready, rsp_valid, rsp_rdata);
`else
   modport master (output req_valid, req_write, req_addr, req_wdata,
                   input  req_ready, rsp_valid, rsp_rdata);
   modport slave  (input  req_valid, req_write, req_addr, req_wdata,
                   output req_ready, rsp_valid, rsp_rdata);
`endif
endinterface

// File: rtl/uart_apb_arb_rr.sv
// Two-way round-robin picker: combinational grant from the valids and the
// last granted id, plus the last-grant register (resets to 1 so port 0 wins
// the first contention).
module uart_rr_arb2
   import uart_apb_pkg::*;
(
   input  logic       clk,
   input  logic       rstn,
   input  logic [1:0] valid_i,
   input  logic       upd_i,
   output logic       gnt_valid_o,
   output id_t        gnt_o,
   output id_t        last_gnt_o
);

   id_t last_gnt_q, last_gnt_d;

   // Pick the lone valid port, or the one not granted last on contention
   always_comb begin
      gnt_valid_o = |valid_i;
      gnt_o       = last_gnt_q;
      if (valid_i == 2'b11) gnt_o = ~last_gnt_q;
      else if (valid_i[1])  gnt_o = 1'b1;
      else if (valid_i[0])  gnt_o = 1'b0;
      last_gnt_d  = upd_i ? gnt_o : last_gnt_q;
   end

   // Last-grant register
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) last_gnt_q <= 1'b1;
      else       last_gnt_q <= last_gnt_d;
   end

   assign last_gnt_o = last_gnt_q;

endmodule

// File: rtl/uart_apb_arb.sv
// Two-requester APB master in front of the UART register slave (no pready):
// round-robin accept in IDLE, fixed SETUP/ACCESS transfer, one-cycle
// response pulse to the issuing port.
// Optional macro UART_ARB_LOCK_EN: per-command lock keeping the grant on a
// port for up to LOCK_MAX_TXN consecutive locked completions.
module uart_apb_arb
   import uart_apb_pkg::*;
#(
   parameter int unsigned ADDR_W       = 4,
   parameter int unsigned DATA_W       = 32,
   parameter int unsigned LOCK_MAX_TXN = 4
) (
   input  logic              clk,
   input  logic              rstn,
   uart_apb_arb_if.slave     m0,
   uart_apb_arb_if.slave     m1,
   output logic [ADDR_W-1:0] paddr_o,
   output logic [DATA_W-1:0] pwdata_o,
   output logic              psel_o,
   output logic              penable_o,
   output logic              pwrite_o,
   input  logic [DATA_W-1:0] prdata_i,
   output logic              busy_o,
   output logic              gnt_id_o
);

   state_e            state_q, state_d;
   logic [1:0]        req_v;
   logic              gnt_valid;
   id_t               gnt, last_gnt, id_q;
   logic              accept;

   logic              sel_write;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wdata;

   logic [ADDR_W-1:0] paddr_q;
   logic [DATA_W-1:0] pwdata_q;
   logic              psel_q, penable_q, pwrite_q;
   logic [1:0]        rsp_valid_q;
   logic [DATA_W-1:0] rdata0_q, rdata1_q;

`ifdef UART_ARB_LOCK_EN
   localparam int unsigned CNT_W = $clog2(LOCK_MAX_TXN + 1);

   logic              lock_act_q;
   id_t               lock_id_q;
   logic [CNT_W-1:0]  lock_cnt_q;
   logic              cmd_lock_q;
   logic              sel_lock;

   // While a lock is held only the owning port is visible to the picker
   assign req_v    = {m1.req_valid & (~lock_act_q | (lock_id_q == 1'b1)),
                      m0.req_valid & (~lock_act_q | (lock_id_q == 1'b0))};
   assign sel_lock = (gnt == 1'b1) ? m1.req_lock : m0.req_lock;
`else
   logic              unused_lock_cfg;

   assign req_v           = {m1.req_valid, m0.req_valid};
   assign unused_lock_cfg = (LOCK_MAX_TXN != 0);
`endif

   uart_rr_arb2 u_arb (
      .clk         (clk),
      .rstn        (rstn),
      .valid_i     (req_v),
      .upd_i       (accept),
      .gnt_valid_o (gnt_valid),
      .gnt_o       (gnt),
      .last_gnt_o  (last_gnt)
   );

   assign sel_write = (gnt == 1'b1) ? m1.req_write : m0.req_write;
   assign sel_addr  = (gnt == 1'b1) ? m1.req_addr  : m0.req_addr;
   assign sel_wdata = (gnt == 1'b1) ? m1.req_wdata : m0.req_wdata;

   // FSM state register
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // Next state and request handshake
   always_comb begin
      state_d      = state_q;
      accept       = 1'b0;
      m0.req_ready = 1'b0;
      m1.req_ready = 1'b0;
      case (state_q)
         IDLE: begin
            if (gnt_valid) begin
               accept       = 1'b1;
               m0.req_ready = (gnt == 1'b0);
               m1.req_ready = (gnt == 1'b1);
               state_d      = SETUP;
            end
         end
         SETUP:   state_d = ACCESS;
         ACCESS:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Registered APB outputs, read-data capture and response pulse
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         paddr_q     <= '0;
         pwdata_q    <= '0;
         psel_q      <= 1'b0;
         penable_q   <= 1'b0;
         pwrite_q    <= 1'b0;
         id_q        <= '0;
         rsp_valid_q <= '0;
         rdata0_q    <= '0;
         rdata1_q    <= '0;
      end else begin
         rsp_valid_q <= '0;
         case (state_q)
            IDLE: begin
               if (accept) begin
                  psel_q   <= 1'b1;
                  paddr_q  <= sel_addr;
                  pwdata_q <= sel_wdata;
                  pwrite_q <= sel_write;
                  id_q     <= gnt;
               end
            end
            SETUP: penable_q <= 1'b1;
            ACCESS: begin
               psel_q            <= 1'b0;
               penable_q         <= 1'b0;
               rsp_valid_q[id_q] <= 1'b1;
               if (id_q == 1'b0) rdata0_q <= pwrite_q ? '0 : prdata_i;
               else              rdata1_q <= pwrite_q ? '0 : prdata_i;
            end
            default: ;
         endcase
      end
   end

`ifdef UART_ARB_LOCK_EN
   // Lock tracking: a locked completion keeps the grant, a plain completion
   // or the LOCK_MAX_TXN-th consecutive locked one releases it
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         lock_act_q <= 1'b0;
         lock_id_q  <= '0;
         lock_cnt_q <= '0;
         cmd_lock_q <= 1'b0;
      end else begin
         if (accept) cmd_lock_q <= sel_lock;
         if (state_q == ACCESS) begin
            if (cmd_lock_q && (32'(lock_cnt_q) + 32'd1 < LOCK_MAX_TXN)) begin
               lock_act_q <= 1'b1;
               lock_id_q  <= id_q;
               lock_cnt_q <= lock_cnt_q + 1'b1;
            end else begin
               lock_act_q <= 1'b0;
               lock_cnt_q <= '0;
            end
         end
      end
   end
`endif

   assign paddr_o      = paddr_q;
   assign pwdata_o     = pwdata_q;
   assign psel_o       = psel_q;
   assign penable_o    = penable_q;
   assign pwrite_o     = pwrite_q;
   assign busy_o       = (state_q != IDLE);
   assign gnt_id_o     = last_gnt;
   assign m0.rsp_valid = rsp_valid_q[0];
   assign m1.rsp_valid = rsp_valid_q[1];
   assign m0.rsp_rdata = rdata0_q;
   assign m1.rsp_rdata = rdata1_q;

endmodule

// File: doc/uart_apb_arb.md
Name: uart_apb_arb

Overview:
- Two-requester APB master that shares the UART register interface slave between two on-chip clients, for example the CPU bridge and an RX-drain/TX-refill engine.
- Accepts simple valid/ready commands from each requester, arbitrates round-robin, and drives one APB setup+access transfer per command.
- Returns a one-cycle response pulse, carrying read data for reads, to the requester that issued the command.
- Sits directly in front of the UART register slave, which has no pready: every transfer is a fixed two-phase transfer.

Parameters:
- ADDR_W, 4, APB/register address width.
- DATA_W, 32, APB data width.
- LOCK_MAX_TXN, 4, maximum consecutive locked transactions before forced release (used only with UART_ARB_LOCK_EN).

Ports:
- clk  in  1  clock
- rstn  in  1  reset, asynchronous, active-low
- mN_req_valid  in  1  requester N (N=0,1) command valid
- mN_req_ready  out  1  requester N command accepted this cycle
- mN_req_write  in  1  1=write, 0=read
- mN_req_addr  in  ADDR_W  register address
- mN_req_wdata  in  DATA_W  write data
- mN_rsp_valid  out  1  one-cycle completion pulse
- mN_rsp_rdata  out  DATA_W  read data, valid with rsp_valid
- paddr_o  out  ADDR_W  APB address
- pwdata_o  out  DATA_W  APB write data
- psel_o  out  1  APB select
- penable_o  out  1  APB enable
- pwrite_o  out  1  APB direction
- prdata_i  in  DATA_W  APB read data, valid during the access phase
- busy_o  out  1  transfer in progress (state != IDLE)
- gnt_id_o  out  1  id of the current or last granted requester

Behaviour:
- FSM states are IDLE, SETUP and ACCESS.
- IDLE:
  - mN_req_ready = (state==IDLE) && arbiter picks N. This is combinational from valid and last_gnt.
  - On valid&&ready: latch write, addr, wdata and id; update last_gnt; go to SETUP.
  - At most one ready is asserted per cycle.
- SETUP (1 cycle): psel_o=1, penable_o=0; paddr_o, pwdata_o and pwrite_o driven from the latched command. Go to ACCESS.
- ACCESS (1 cycle): psel_o=1, penable_o=1, APB fields unchanged. prdata_i is sampled at the end of the cycle. Go to IDLE.
- Cycle following ACCESS:
  - mN_rsp_valid=1 for the latched id only.
  - mN_rsp_rdata = sampled prdata_i for reads, 0 for writes. rsp_rdata holds until the next response to that port.
  - A new command may be accepted in this same cycle.
- Latency: accept at T → SETUP at T+1 → ACCESS at T+2 → rsp_valid at T+3. Peak throughput is one transfer per 3 cycles.
- Round-robin:
  - If only one port is valid, that port wins.
  - If both are valid, the port != last_gnt wins.
  - last_gnt resets to 1, so port 0 wins the first contention.
- Requesters must hold the command stable while valid && !ready. The arbiter never drops or reorders an accepted command.
- All APB outputs are registered. pwdata_o and paddr_o hold their last values in IDLE; psel_o and penable_o are 0 in IDLE.
- Read side effects in the slave (for example the RX FIFO pop on address 1) are the requester's concern. The arbiter issues exactly one APB transfer per accepted command.
- Reset values: psel_o, penable_o, pwrite_o, busy_o = 0; paddr_o, pwdata_o, mN_rsp_rdata = 0; mN_rsp_valid = 0; gnt_id_o = 1; state = IDLE.
- Reset mid-transfer: asynchronous return to IDLE, psel_o and penable_o drop immediately, and no rsp_valid is issued for the aborted command.

Optional Feature:
- Macro: UART_ARB_LOCK_EN.
- With the macro defined:
  - Adds input mN_req_lock, sampled with the command.
  - A completed transaction with lock=1 keeps the grant on that port: in IDLE, only that port may be made ready.
  - The lock is released by completion of a lock=0 transaction, or forcibly after LOCK_MAX_TXN consecutive locked completions; round-robin then resumes with the other port favoured.
  - The lock is cleared on reset.
  - Purpose: atomic status read followed by write-1-to-clear.
- Without the macro: no lock ports; pure round-robin.

Decomposition:
- Package uart_apb_pkg:
  - State enum {IDLE, SETUP, ACCESS}.
  - Requester-id width.
  - UART register address constants: TX=0, RX=1, BAUD=2, CONF=3, RXTRIG=4, TXTRIG=5, DELAY=6, STATUS=7, RXFIFO_STAT=8, TXFIFO_STAT=9.
- Sub-module uart_rr_arb2: 2-way round-robin picker (combinational grant from valid and last_gnt, plus the last_gnt register with its update enable).

Test Plan:
1. m0 write addr 0x0, data 0x55, accepted at T → T+1: psel=1, penable=0, paddr=0, pwdata=0x55, pwrite=1; T+2: penable=1; T+3: m0_rsp_valid=1, psel=0.
2. m1 read addr 0x7, prdata_i=0x0000_0002 during ACCESS → m1_rsp_valid at T+3 with m1_rsp_rdata=0x2; m0_rsp_valid stays 0.
3. Both ports continuously valid after reset, 6 commands → grant order 0,1,0,1,0,1; one accept every 3 cycles.
4. rstn asserted during ACCESS of an m0 read → psel and penable 0 immediately, no rsp_valid; after release, simultaneous requests grant m0 first.
5. m1 is mid-transfer while m0 raises valid with addr 0x3 → m0_req_ready stays 0 until the cycle m1_rsp_valid=1, then m0 is accepted; its fields appear unchanged on APB.
6. (UART_ARB_LOCK_EN, LOCK_MAX_TXN=2) m1 issues 3 locked reads of addr 0x7 while m0 is pending → order m1, m1, m0, m1.
